toast_dual_mem: RTL and testbench
=================================

TOAST_DUAL_MEM -- requirements
Module: toast_dual_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096: number of 32-bit words.
REQ-002 SHALL have parameter RD_LATENCY, default 1: read latency in cycles, legal range 1..4.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000: byte address of the test-result word.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 imem_addr_i  input  32  instruction byte address.
REQ-007 imem_data_o  output  32  instruction read data.
REQ-008 imem_valid_o  output  1  imem_data_o holds data for the address sampled RD_LATENCY cycles earlier.
REQ-009 dmem_addr_i  input  32  data byte address.
REQ-010 dmem_wr_byte_en_i  input  4  per-byte write enables; bit n selects data bits [8n+7:8n].
REQ-011 dmem_wr_data_i  input  32  write data.
REQ-012 dmem_rst_i  input  1  forces zero read data for this cycle's request.
REQ-013 dmem_rd_data_o  output  32  data read data.
REQ-014 dmem_valid_o  output  1  dmem_rd_data_o valid, same timing as imem_valid_o.
REQ-015 fault_o  output  1  sticky flag: out-of-range access seen.
REQ-016 done_o  output  1  sticky flag: tohost word written.
REQ-017 pass_o  output  1  tohost value was exactly 1.
REQ-018 fail_id_o  output  31  tohost value bits [31:1].

Function
REQ-019 Word index SHALL be addr[31:2]; addr[1:0] SHALL be ignored on both ports.
REQ-020 Each port SHALL sample its address every cycle after reset release and present the word RD_LATENCY cycles later.
REQ-021 Valid output SHALL assert for each sampled request after RD_LATENCY cycles; valid is 0 for the first RD_LATENCY cycles after reset release.
REQ-022 Write and read of the same word in one cycle SHALL return the old word on either port (read-before-write).
REQ-023 Bytes with enable 0 SHALL be left unchanged; an all-zero enable SHALL perform no write.
REQ-024 With dmem_rst_i high, that request SHALL return 32'h0 after RD_LATENCY; any write in the same cycle SHALL still take effect.
REQ-025 Index >= MEM_DEPTH SHALL read 0 and suppress the write.
REQ-026 Index >= MEM_DEPTH SHALL set fault_o the next cycle; fault_o SHALL hold until reset.
REQ-027 A dmem write with all four enables set and dmem_addr_i == TOHOST_ADDR SHALL set done_o next cycle.
REQ-028 The same tohost write SHALL latch pass_o = (data == 1) and fail_id_o = data[31:1].
REQ-029 After done_o sets, later tohost writes SHALL NOT change pass_o or fail_id_o (first result wins).
REQ-030 The tohost write SHALL also update memory normally.

Reset
REQ-031 Reset_n low SHALL clear within that event: all pipeline stages, imem_data_o, dmem_rd_data_o, both valids, fault_o, done_o, pass_o, fail_id_o.
REQ-032 Reset SHALL NOT clear memory contents; the bench preloads them by hierarchical access or file load.
REQ-033 Reset mid-read SHALL discard in-flight reads; no valid SHALL appear for them after release.

Configuration
REQ-034 Macro TOAST_MEM_TOHOST_EN defined: REQ-027..REQ-029 SHALL be implemented.
REQ-035 Macro TOAST_MEM_TOHOST_EN absent: done_o, pass_o and fail_id_o SHALL be tied 0, with no tohost logic; memory behaviour SHALL be unchanged.

Structure
REQ-036 Package toast_mem_pkg SHALL hold the MEM_DEPTH, RD_LATENCY and TOHOST_ADDR defaults, and the legal RD_LATENCY bounds.
REQ-037 The delay line SHALL be sub-module toast_mem_rd_pipe (parameters WIDTH and DEPTH, data plus valid), instantiated once per port.

Verification
REQ-038 RD_LATENCY=1:
- Preload word 5 with 32'hDEADBEEF.
- Drive imem_addr_i=0x14.
- Expect imem_data_o=DEADBEEF with imem_valid_o=1 exactly 1 cycle later.
REQ-039 RD_LATENCY=3:
- Back-to-back dmem reads of 0x0, 0x4, 0x8.
- Expect data on 3 consecutive cycles starting 3 cycles after the first.
REQ-040 Byte-enable merge:
- Word 0x2000 = 32'h11223344.
- Write byte_en=4'b0101, data=32'hAABBCCDD.
- Expect readback 32'h11BB33DD.
REQ-041 Same-cycle write and read:
- Word = 32'h0; write 32'hFFFFFFFF to it while reading it.
- Expect 0 on that read and FFFFFFFF on the next read.
REQ-042 Out-of-range access:
- dmem_addr_i = MEM_DEPTH*4.
- Expect read data 0, fault_o=1 next cycle, memory unchanged.
- Expect fault_o to stay 1 until Reset_n is pulsed.
REQ-043 Tohost, with macro defined:
- Write 1 to TOHOST_ADDR: expect done_o=1, pass_o=1.
- After reset, write 32'h7: expect done_o=1, pass_o=0, fail_id_o=3.
- A second write of 1 leaves pass_o=0.
- Without the macro, all three outputs stay 0.

Source files
------------

// File: rtl/toast_mem_pkg.sv
// Shared constants, bus payload types and helpers for the dual-port test memory.
// Holds the default geometry, the legal read-latency window and the tohost address.
package toast_mem_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned IDX_W          = 30;
    localparam int unsigned MEM_DEPTH_DEF  = 4096;
    localparam int unsigned RD_LATENCY_DEF = 1;
    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 4;
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

    // One data-port request as sampled on a clock edge.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              rst;
    } dmem_req_t;

    // Expand per-byte enables to a 32-bit bit mask.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(BE_W); b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/toast_dual_mem_if.sv
// Instruction and data port bundle of toast_dual_mem.
// slave: memory side (addresses/write data in, read data/valids out); master: core side.
interface toast_dual_mem_if
    import toast_mem_pkg::*;
    ;
    logic [DATA_W-1:0] imem_addr_i;
    logic [DATA_W-1:0] imem_data_o;
    logic              imem_valid_o;
    logic [DATA_W-1:0] dmem_addr_i;
    logic [BE_W-1:0]   dmem_wr_byte_en_i;
    logic [DATA_W-1:0] dmem_wr_data_i;
    logic              dmem_rst_i;
    logic [DATA_W-1:0] dmem_rd_data_o;
    logic              dmem_valid_o;

    modport slave (
        input  imem_addr_i, dmem_addr_i, dmem_wr_byte_en_i, dmem_wr_data_i, dmem_rst_i,
        output imem_data_o, imem_valid_o, dmem_rd_data_o, dmem_valid_o
    );

    modport master (
        output imem_addr_i, dmem_addr_i, dmem_wr_byte_en_i, dmem_wr_data_i, dmem_rst_i,
        input  imem_data_o, imem_valid_o, dmem_rd_data_o, dmem_valid_o
    );
endinterface

// File: rtl/toast_mem_rd_pipe.sv
// Fixed-depth read-data delay line with a valid bit per stage.
// Ports: clk, rst_n (async active-low), in_data_i/in_valid_i -> out_data_o/out_valid_o
// after DEPTH rising edges. Reset empties every stage.
module toast_mem_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Shift one stage per cycle.
    always_comb begin
        data_d[0]  = in_data_i;
        valid_d    = '0;
        valid_d[0] = in_valid_i;
        for (int s = 1; s < int'(DEPTH); s++) begin
            data_d[s]  = data_q[s-1];
            valid_d[s] = valid_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                data_q[s] <= data_d[s];
            end
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q[DEPTH-1];
    assign out_valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/toast_dual_mem.sv
// Dual-port (instruction read / data read-write) test memory with tohost result capture.
// Ports: Clk, Reset_n (async active-low), bus (toast_dual_mem_if.slave),
//        fault_o (sticky out-of-range), done_o/pass_o/fail_id_o (tohost result).
// Optional feature: define TOAST_MEM_TOHOST_EN to build the tohost capture; otherwise
// done_o/pass_o/fail_id_o are tied 0.
// RD_LATENCY must lie in RD_LATENCY_MIN..RD_LATENCY_MAX. Memory contents survive reset.
module toast_dual_mem
    import toast_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned RD_LATENCY  = RD_LATENCY_DEF,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    toast_dual_mem_if.slave      bus,
    output logic                 fault_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [30:0]          fail_id_o
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    dmem_req_t         d_req;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  d_idx;
    logic              i_in_range;
    logic              d_in_range;
    logic [DATA_W-1:0] i_rd_word;
    logic [DATA_W-1:0] d_mem_word;
    logic [DATA_W-1:0] d_rd_word;
    logic [DATA_W-1:0] d_wr_mask;
    logic [DATA_W-1:0] d_wr_word;
    logic              d_wr_en;
    logic              fault_q;
    logic              fault_d;
    logic              unused_addr_bits;

    // Address decode, read mux and byte-merge of the write word.
    always_comb begin
        d_req = '{addr: bus.dmem_addr_i, be: bus.dmem_wr_byte_en_i,
                  wdata: bus.dmem_wr_data_i, rst: bus.dmem_rst_i};
        i_idx      = bus.imem_addr_i[31:2];
        d_idx      = d_req.addr[31:2];
        i_in_range = 32'({2'b00, i_idx}) < 32'(MEM_DEPTH);
        d_in_range = 32'({2'b00, d_idx}) < 32'(MEM_DEPTH);
        i_rd_word  = i_in_range ? mem_q[i_idx[AW-1:0]] : '0;
        d_mem_word = d_in_range ? mem_q[d_idx[AW-1:0]] : '0;
        d_rd_word  = d_req.rst ? '0 : d_mem_word;
        d_wr_mask  = byte_mask(d_req.be);
        d_wr_word  = (d_mem_word & ~d_wr_mask) | (d_req.wdata & d_wr_mask);
        d_wr_en    = d_in_range && (|d_req.be);
        fault_d    = fault_q | ~i_in_range | ~d_in_range;
    end

    assign unused_addr_bits = ^{bus.imem_addr_i[1:0], d_req.addr[1:0]};

    // Storage; reads above see the pre-write word, giving read-before-write.
    always_ff @(posedge Clk) begin
        if (d_wr_en) begin
            mem_q[d_idx[AW-1:0]] <= d_wr_word;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fault_q <= 1'b0;
        else          fault_q <= fault_d;
    end

    assign fault_o = fault_q;

    toast_mem_rd_pipe #(.WIDTH(DATA_W), .DEPTH(RD_LATENCY)) u_imem_pipe (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .in_data_i  (i_rd_word),
        .in_valid_i (1'b1),
        .out_data_o (bus.imem_data_o),
        .out_valid_o(bus.imem_valid_o)
    );

    toast_mem_rd_pipe #(.WIDTH(DATA_W), .DEPTH(RD_LATENCY)) u_dmem_pipe (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .in_data_i  (d_rd_word),
        .in_valid_i (1'b1),
        .out_data_o (bus.dmem_rd_data_o),
        .out_valid_o(bus.dmem_valid_o)
    );

`ifdef TOAST_MEM_TOHOST_EN
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [30:0] fail_id_q, fail_id_d;
    logic        tohost_hit;

    // First full-word write to tohost wins; later writes only update memory.
    always_comb begin
        tohost_hit = (d_req.addr == TOHOST_ADDR) && (d_req.be == 4'hF);
        done_d     = done_q | tohost_hit;
        pass_d     = pass_q;
        fail_id_d  = fail_id_q;
        if (tohost_hit && !done_q) begin
            pass_d    = (d_req.wdata == 32'd1);
            fail_id_d = d_req.wdata[31:1];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_id_q <= '0;
        end else begin
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_id_q <= fail_id_d;
        end
    end

    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign fail_id_o = fail_id_q;
`else
    localparam logic [31:0] unused_tohost_addr = TOHOST_ADDR;

    assign done_o    = 1'b0;
    assign pass_o    = 1'b0;
    assign fail_id_o = '0;
`endif

endmodule

// File: tb/tb_toast_dual_mem.sv
// Directed bench for toast_dual_mem: one instance at RD_LATENCY=1, one at RD_LATENCY=3,
// driven with identical stimulus so both memories hold the same contents.
module tb_toast_dual_mem;
    import toast_mem_pkg::*;

`ifdef TOAST_MEM_TOHOST_EN
    localparam bit TH = 1'b1;
`else
    localparam bit TH = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    toast_dual_mem_if b1();
    toast_dual_mem_if b3();

    logic        f1, d1, p1, f3, d3, p3;
    logic [30:0] id1, id3;

    toast_dual_mem #(.RD_LATENCY(1)) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b1),
        .fault_o(f1), .done_o(d1), .pass_o(p1), .fail_id_o(id1)
    );

    toast_dual_mem #(.RD_LATENCY(3)) u_dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b3),
        .fault_o(f3), .done_o(d3), .pass_o(p3), .fail_id_o(id3)
    );

    int unsigned n_vec = 0;
    int unsigned n_miscmp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data, input logic rst);
        b1.dmem_addr_i = addr; b1.dmem_wr_byte_en_i = be;
        b1.dmem_wr_data_i = data; b1.dmem_rst_i = rst;
        b3.dmem_addr_i = addr; b3.dmem_wr_byte_en_i = be;
        b3.dmem_wr_data_i = data; b3.dmem_rst_i = rst;
    endtask

    task automatic set_imem(input logic [31:0] addr);
        b1.imem_addr_i = addr;
        b3.imem_addr_i = addr;
    endtask

    // Single write cycle; leaves the address on the bus with enables cleared.
    task automatic dwr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        drive(addr, be, data, 1'b0);
        step();
        drive(addr, 4'h0, data, 1'b0);
    endtask

    task automatic pulse_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_imem(32'h0);
        drive(32'h0, 4'h0, 32'h0, 1'b0);

        // Reset values
        step();
        chk("rst_ivalid1", 32'(b1.imem_valid_o), 32'd0);
        chk("rst_dvalid3", 32'(b3.dmem_valid_o), 32'd0);
        chk("rst_ddata1", b1.dmem_rd_data_o, 32'h0);
        chk("rst_fault", 32'(f1), 32'd0);
        chk("rst_done", 32'(d1), 32'd0);
        Reset_n = 1'b1;

        // Valid start-up per latency
        step();
        chk("lat1_valid_c1", 32'(b1.imem_valid_o), 32'd1);
        chk("lat3_valid_c1", 32'(b3.dmem_valid_o), 32'd0);
        step();
        chk("lat3_valid_c2", 32'(b3.dmem_valid_o), 32'd0);
        step();
        chk("lat3_valid_c3", 32'(b3.dmem_valid_o), 32'd1);

        // Preload
        dwr(32'h10, 4'hF, 32'h1234_5678);
        dwr(32'h14, 4'hF, 32'hDEAD_BEEF);
        dwr(32'h00, 4'hF, 32'hA000_0000);
        dwr(32'h04, 4'hF, 32'hA000_0001);
        dwr(32'h08, 4'hF, 32'hA000_0002);

        // imem latency 1 and ignored low address bits
        set_imem(32'h10);
        step();
        chk("imem_w4", b1.imem_data_o, 32'h1234_5678);
        set_imem(32'h14);
        step();
        chk("imem_w5", b1.imem_data_o, 32'hDEAD_BEEF);
        chk("imem_w5_valid", 32'(b1.imem_valid_o), 32'd1);
        set_imem(32'h17);
        step();
        chk("imem_low_bits", b1.imem_data_o, 32'hDEAD_BEEF);

        // Back-to-back dmem reads, latency 3 vs latency 1
        drive(32'h10, 4'h0, 32'h0, 1'b0);
        step(); step(); step();
        chk("lat3_pre", b3.dmem_rd_data_o, 32'h1234_5678);
        drive(32'h0, 4'h0, 32'h0, 1'b0);
        step();
        chk("lat3_t1", b3.dmem_rd_data_o, 32'h1234_5678);
        chk("lat1_t1", b1.dmem_rd_data_o, 32'hA000_0000);
        drive(32'h4, 4'h0, 32'h0, 1'b0);
        step();
        chk("lat3_t2", b3.dmem_rd_data_o, 32'h1234_5678);
        chk("lat1_t2", b1.dmem_rd_data_o, 32'hA000_0001);
        drive(32'h8, 4'h0, 32'h0, 1'b0);
        step();
        chk("lat3_t3", b3.dmem_rd_data_o, 32'hA000_0000);
        chk("lat1_t3", b1.dmem_rd_data_o, 32'hA000_0002);
        drive(32'h10, 4'h0, 32'h0, 1'b0);
        step();
        chk("lat3_t4", b3.dmem_rd_data_o, 32'hA000_0001);
        step();
        chk("lat3_t5", b3.dmem_rd_data_o, 32'hA000_0002);
        step();
        chk("lat3_t6", b3.dmem_rd_data_o, 32'h1234_5678);

        // Byte-enable merge and all-zero enable
        dwr(32'h2000, 4'hF, 32'h1122_3344);
        dwr(32'h2000, 4'b0101, 32'hAABB_CCDD);
        step();
        chk("be_merge", b1.dmem_rd_data_o, 32'h11BB_33DD);
        dwr(32'h2000, 4'h0, 32'hFFFF_FFFF);
        step();
        chk("be_zero", b1.dmem_rd_data_o, 32'h11BB_33DD);

        // Same-cycle write and read on both ports
        dwr(32'h30, 4'hF, 32'h0);
        set_imem(32'h30);
        drive(32'h30, 4'hF, 32'hFFFF_FFFF, 1'b0);
        step();
        chk("rbw_dmem", b1.dmem_rd_data_o, 32'h0);
        chk("rbw_imem", b1.imem_data_o, 32'h0);
        drive(32'h30, 4'h0, 32'h0, 1'b0);
        step();
        chk("rbw_after", b1.dmem_rd_data_o, 32'hFFFF_FFFF);

        // dmem_rst_i zeroes read but write still lands
        drive(32'h30, 4'b0001, 32'h0000_0055, 1'b1);
        step();
        chk("drst_zero", b1.dmem_rd_data_o, 32'h0);
        drive(32'h30, 4'h0, 32'h0, 1'b0);
        step();
        chk("drst_write", b1.dmem_rd_data_o, 32'hFFFF_FF55);

        // Out-of-range access
        chk("fault_idle", 32'(f1), 32'd0);
        set_imem(32'h14);
        drive(32'h4000, 4'hF, 32'h0BAD_F00D, 1'b0);
        step();
        chk("oor_read", b1.dmem_rd_data_o, 32'h0);
        chk("oor_fault1", 32'(f1), 32'd1);
        chk("oor_fault3", 32'(f3), 32'd1);
        drive(32'h0, 4'h0, 32'h0, 1'b0);
        step();
        chk("oor_nowrite", b1.dmem_rd_data_o, 32'hA000_0000);
        step(); step();
        chk("fault_sticky", 32'(f1), 32'd1);

        // Reset mid-read: in-flight requests are dropped, memory kept
        drive(32'h14, 4'h0, 32'h0, 1'b0);
        step();
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid3", 32'(b3.dmem_valid_o), 32'd0);
        chk("mid_rst_fault", 32'(f1), 32'd0);
        chk("mid_rst_data1", b1.dmem_rd_data_o, 32'h0);
        step();
        Reset_n = 1'b1;
        step();
        chk("inflight_drop1", 32'(b3.dmem_valid_o), 32'd0);
        step();
        chk("inflight_drop2", 32'(b3.dmem_valid_o), 32'd0);
        step();
        chk("post_rst_valid3", 32'(b3.dmem_valid_o), 32'd1);
        chk("mem_kept", b3.dmem_rd_data_o, 32'hDEAD_BEEF);

        // Tohost capture
        chk("done_idle", 32'(d1), 32'd0);
        dwr(32'h1000, 4'hF, 32'h1);
        chk("th_pass_done", 32'(d1), 32'(TH));
        chk("th_pass_pass", 32'(p1), 32'(TH));
        chk("th_pass_id", 32'(id1), 32'h0);
        pulse_reset();
        chk("th_rst_done", 32'(d1), 32'd0);
        dwr(32'h1000, 4'b0111, 32'h1);
        chk("th_partial", 32'(d1), 32'd0);
        dwr(32'h1000, 4'hF, 32'h7);
        chk("th_fail_done", 32'(d1), 32'(TH));
        chk("th_fail_pass", 32'(p1), 32'd0);
        chk("th_fail_id", 32'(id1), TH ? 32'd3 : 32'd0);
        dwr(32'h1000, 4'hF, 32'h1);
        chk("th_first_wins_pass", 32'(p1), 32'd0);
        chk("th_first_wins_id", 32'(id1), TH ? 32'd3 : 32'd0);
        chk("th_first_wins_done", 32'(d1), 32'(TH));
        step();
        chk("th_mem", b1.dmem_rd_data_o, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
